// File: rtl/wb_csr_pkg.sv
// Register map constants and helpers shared by the wb_csr_slave register block.
package wb_csr_pkg;

  localparam logic [7:0] ADDR_ID         = 8'h00;
  localparam logic [7:0] ADDR_SCRATCH    = 8'h04;
  localparam logic [7:0] ADDR_CTRL       = 8'h08;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h10;
  localparam logic [7:0] ADDR_CTRL_BASE  = 8'h40;
  localparam logic [7:0] ADDR_STAT_BASE  = 8'h80;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_SNAP_BIT = 1;
  localparam int CTRL_CLR_BIT  = 2;

  localparam logic [31:0] ID_DEFAULT = 32'h5146_0001;

  // Replace only the byte lanes selected in lane_mask.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] lane_mask);
    return (old_val & ~lane_mask) | (new_val & lane_mask);
  endfunction

endpackage

// File: rtl/wb_csr_w1c.sv
// Sticky-set / write-1-clear status register; a set and clear on the same edge leaves the bit set.
module wb_csr_w1c #(
  parameter int W = 8
) (
  input  logic         wb_clk,
  input  logic         rst_n,
  input  logic [W-1:0] set_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = (stat_q & ~clr_i) | set_i;
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign q_o = stat_q;

endmodule

// File: rtl/wb_csr_slave.sv
// Wishbone classic CSR block: ID, scratch, control pulses, W1C IRQ, config array, status snapshot.
// Define WB_CSR_ERR_EN to answer unmapped accesses with wb_err_o instead of wb_ack_o.
module wb_csr_slave
  import wb_csr_pkg::*;
#(
  parameter int          DATA     = 32,
  parameter int          ADDR     = 32,
  parameter int          NUM_CTRL = 8,
  parameter int          NUM_STAT = 8,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                     wb_clk,
  input  logic                     rst_n,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDR-1:0]          wb_adr_i,
  input  logic [DATA-1:0]          wb_dat_i,
  input  logic [DATA/8-1:0]        wb_sel_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [DATA-1:0]          wb_dat_o,
  output logic                     ctrl_en_o,
  output logic                     cnt_clr_o,
  output logic [NUM_CTRL*DATA-1:0] ctrl_o,
  input  logic [NUM_STAT*DATA-1:0] stat_i,
  input  logic [7:0]               evt_i,
  output logic                     irq_o
);

  logic            req, hi_bad, hit_ctrl, hit_stat, mapped;
  logic [7:0]      off;
  logic [3:0]      k_idx;
  logic [DATA-1:0] rdata, wmask;
  logic [7:0]      irq_stat, irq_clr;
  logic            unused_adr;

  logic            ack_q, ack_d, err_q, err_d;
  logic            en_q, en_d, clr_q, clr_d;
  logic [DATA-1:0] dat_q, dat_d, scratch_q, scratch_d;
  logic [7:0]      mask_q, mask_d;
  logic [DATA-1:0] ctrl_q [NUM_CTRL];
  logic [DATA-1:0] ctrl_d [NUM_CTRL];
  logic [DATA-1:0] snap_q [NUM_STAT];
  logic [DATA-1:0] snap_d [NUM_STAT];

  assign unused_adr = ^wb_adr_i[1:0];

  // Ack/err gating keeps a master that holds stb through the response from being served twice.
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign off      = {wb_adr_i[7:2], 2'b00};
  assign k_idx    = wb_adr_i[5:2];
  assign hi_bad   = |wb_adr_i[ADDR-1:8];
  assign hit_ctrl = (off[7:6] == ADDR_CTRL_BASE[7:6]) && (int'(k_idx) < NUM_CTRL);
  assign hit_stat = (off[7:6] == ADDR_STAT_BASE[7:6]) && (int'(k_idx) < NUM_STAT);
  assign mapped   = !hi_bad && (off == ADDR_ID || off == ADDR_SCRATCH || off == ADDR_CTRL ||
                                off == ADDR_IRQ_STATUS || off == ADDR_IRQ_MASK ||
                                hit_ctrl || hit_stat);

  for (genvar gi = 0; gi < DATA/8; gi++) begin : g_lane
    assign wmask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
  end

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (off)
        ADDR_ID:         rdata = ID_VALUE;
        ADDR_SCRATCH:    rdata = scratch_q;
        ADDR_CTRL:       rdata[CTRL_EN_BIT] = en_q;
        ADDR_IRQ_STATUS: rdata[7:0] = irq_stat;
        ADDR_IRQ_MASK:   rdata[7:0] = mask_q;
        default:         ;
      endcase
      for (int k = 0; k < NUM_CTRL; k++)
        if (hit_ctrl && k_idx == 4'(k)) rdata = ctrl_q[k];
      for (int k = 0; k < NUM_STAT; k++)
        if (hit_stat && k_idx == 4'(k)) rdata = snap_q[k];
    end
  end

  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    clr_d     = 1'b0;
    dat_d     = dat_q;
    scratch_d = scratch_q;
    en_d      = en_q;
    mask_d    = mask_q;
    ctrl_d    = ctrl_q;
    snap_d    = snap_q;
    irq_clr   = '0;
    if (req) begin
`ifdef WB_CSR_ERR_EN
      ack_d = mapped;
      err_d = ~mapped;
      if (mapped && !wb_we_i) dat_d = rdata;
`else
      ack_d = 1'b1;
      if (!wb_we_i) dat_d = rdata;
`endif
      if (mapped && wb_we_i) begin
        case (off)
          ADDR_SCRATCH: scratch_d = byte_merge(scratch_q, wb_dat_i, wmask);
          ADDR_CTRL: begin
            if (wb_sel_i[0]) begin
              en_d  = wb_dat_i[CTRL_EN_BIT];
              clr_d = wb_dat_i[CTRL_CLR_BIT];
              if (wb_dat_i[CTRL_SNAP_BIT])
                for (int k = 0; k < NUM_STAT; k++) snap_d[k] = stat_i[k*DATA +: DATA];
            end
          end
          ADDR_IRQ_STATUS: irq_clr = wb_dat_i[7:0] & wmask[7:0];
          ADDR_IRQ_MASK:   mask_d = (mask_q & ~wmask[7:0]) | (wb_dat_i[7:0] & wmask[7:0]);
          default:         ;
        endcase
        for (int k = 0; k < NUM_CTRL; k++)
          if (hit_ctrl && k_idx == 4'(k)) ctrl_d[k] = byte_merge(ctrl_q[k], wb_dat_i, wmask);
      end
    end
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      dat_q     <= '0;
      scratch_q <= '0;
      mask_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      en_q      <= en_d;
      clr_q     <= clr_d;
      dat_q     <= dat_d;
      scratch_q <= scratch_d;
      mask_q    <= mask_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
    always_ff @(posedge wb_clk or negedge rst_n) begin
      if (!rst_n) ctrl_q[gi] <= '0;
      else        ctrl_q[gi] <= ctrl_d[gi];
    end
    assign ctrl_o[gi*DATA +: DATA] = ctrl_q[gi];
  end

  for (genvar gi = 0; gi < NUM_STAT; gi++) begin : g_snap
    always_ff @(posedge wb_clk or negedge rst_n) begin
      if (!rst_n) snap_q[gi] <= '0;
      else        snap_q[gi] <= snap_d[gi];
    end
  end

  wb_csr_w1c #(.W(8)) u_irq_status (
    .wb_clk (wb_clk),
    .rst_n  (rst_n),
    .set_i  (evt_i),
    .clr_i  (irq_clr),
    .q_o    (irq_stat)
  );

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = dat_q;
  assign ctrl_en_o = en_q;
  assign cnt_clr_o = clr_q;
  assign irq_o     = |(irq_stat & mask_q);

endmodule

// File: tb/tb_wb_csr_slave.sv
// Scoreboard bench for wb_csr_slave; honours WB_CSR_ERR_EN for the unmapped-access cases.
module tb_wb_csr_slave;

  localparam int NUM_CTRL = 8;
  localparam int NUM_STAT = 8;
  localparam logic [31:0] ID = 32'h5146_0001;
`ifdef WB_CSR_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  logic                     wb_clk, rst_n;
  logic                     wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]              wb_adr_i, wb_dat_i;
  logic [3:0]               wb_sel_i;
  logic                     wb_ack_o, wb_err_o;
  logic [31:0]              wb_dat_o;
  logic                     ctrl_en_o, cnt_clr_o, irq_o;
  logic [NUM_CTRL*32-1:0]   ctrl_o;
  logic [NUM_STAT*32-1:0]   stat_i;
  logic [7:0]               evt_i;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   clr_cycles = 0;

  wb_csr_slave #(.DATA(32), .ADDR(32), .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT), .ID_VALUE(ID)) dut (
    .wb_clk    (wb_clk),
    .rst_n     (rst_n),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_dat_o  (wb_dat_o),
    .ctrl_en_o (ctrl_en_o),
    .cnt_clr_o (cnt_clr_o),
    .ctrl_o    (ctrl_o),
    .stat_i    (stat_i),
    .evt_i     (evt_i),
    .irq_o     (irq_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ack/err consumes one scoreboard entry.
  always @(negedge wb_clk) begin
    exp_t e;
    if (cnt_clr_o) clr_cycles++;
    if (rst_n && (wb_ack_o || wb_err_o)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_err", 32'(wb_err_o), 32'(e.err));
        if (e.rd) chk("rdata", wb_dat_o, e.dat);
      end
    end
  end

  // Called at a negedge; the following posedge is the request edge N.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, input logic [7:0] evt,
                      input logic [31:0] exp_dat, input logic exp_err);
    exp_t e;
    e.rd  = !we && !exp_err;
    e.err = exp_err;
    e.dat = exp_dat;
    sb_q.push_back(e);
    $display("txn %s adr=0x%08h wdat=0x%08h sel=%b evt=0x%02h exp=0x%08h err=%0b",
             we ? "WR" : "RD", adr, wdat, sel, evt, exp_dat, exp_err);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = wdat; wb_sel_i = sel; evt_i = evt;
    @(posedge wb_clk); #1;
    evt_i = 8'h00;
    @(negedge wb_clk);
    chk("resp_at_n1", {30'd0, wb_ack_o, wb_err_o}, exp_err ? 32'd1 : 32'd2);
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk);
    chk("single_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    xfer(1'b1, adr, d, sel, 8'h00, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    xfer(1'b0, adr, 32'd0, 4'hF, 8'h00, exp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; evt_i = '0;
    for (int k = 0; k < NUM_STAT; k++) stat_i[k*32 +: 32] = 32'h100 * k + 32'h11;
    repeat (3) @(negedge wb_clk);
    rst_n = 1'b1;
    @(negedge wb_clk);

    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_ctrl_lo", ctrl_o[31:0], 32'd0);
    chk("rst_ctrl_hi", ctrl_o[NUM_CTRL*32-1 -: 32], 32'd0);
    chk("rst_misc", {29'd0, ctrl_en_o, cnt_clr_o, irq_o}, 32'd0);

    rd(32'h00, ID);
    rd(32'h40, 32'h0);

    wr(32'h04, 32'hA5A5_A5A5, 4'b0011);
    rd(32'h04, 32'h0000_A5A5);
    wr(32'h04, 32'h5A5A_5A5A, 4'b1000);
    rd(32'h04, 32'h5A00_A5A5);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    rd(32'h00, ID);

    wr(32'h08, 32'h2, 4'hF);
    for (int k = 0; k < NUM_STAT; k++) stat_i[k*32 +: 32] = 32'h100 * k + 32'h22;
    rd(32'h80, 32'h11);
    rd(32'h9C, 32'h711);
    rd(32'h08, 32'h0);
    wr(32'h08, 32'h1, 4'hF);
    chk("ctrl_en_set", 32'(ctrl_en_o), 32'd1);
    rd(32'h08, 32'h1);
    chk("clr_idle", 32'(clr_cycles), 32'd0);
    wr(32'h08, 32'h4, 4'hF);
    chk("clr_one_cycle", 32'(clr_cycles), 32'd1);
    chk("ctrl_en_clr", 32'(ctrl_en_o), 32'd0);

    evt_i = 8'h08;
    @(negedge wb_clk);
    evt_i = 8'h00;
    chk("irq_masked", 32'(irq_o), 32'd0);
    wr(32'h10, 32'h08, 4'hF);
    chk("irq_on", 32'(irq_o), 32'd1);
    rd(32'h0C, 32'h08);
    xfer(1'b1, 32'h0C, 32'h08, 4'hF, 8'h08, 32'd0, 1'b0);
    chk("irq_set_wins", 32'(irq_o), 32'd1);
    rd(32'h0C, 32'h08);
    wr(32'h0C, 32'h08, 4'hF);
    chk("irq_cleared", 32'(irq_o), 32'd0);
    rd(32'h0C, 32'h00);

    wr(32'h5C, 32'hDEAD_BEEF, 4'hF);
    chk("ctrl_o_top", ctrl_o[NUM_CTRL*32-1 -: 32], 32'hDEAD_BEEF);
    chk("ctrl_o_bot", ctrl_o[31:0], 32'd0);
    rd(32'h5C, 32'hDEAD_BEEF);

    xfer(1'b0, 32'h100, 32'd0, 4'hF, 8'h00, 32'd0, ERR_MODE);
    xfer(1'b0, 32'h60, 32'd0, 4'hF, 8'h00, 32'd0, ERR_MODE);
    xfer(1'b1, 32'h104, 32'h1234_5678, 4'hF, 8'h00, 32'd0, ERR_MODE);
    rd(32'h04, 32'h5A00_A5A5);

    // Reset lands between the request edge and the ack cycle.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h00;
    @(posedge wb_clk); #2;
    rst_n = 1'b0;
    @(negedge wb_clk);
    chk("midrst_ack", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    chk("midrst_dat", wb_dat_o, 32'd0);
    chk("midrst_ctrl", ctrl_o[NUM_CTRL*32-1 -: 32], 32'd0);
    chk("midrst_misc", {29'd0, ctrl_en_o, cnt_clr_o, irq_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk);
    rst_n = 1'b1;
    @(negedge wb_clk);
    rd(32'h00, ID);
    rd(32'h04, 32'h0);
    rd(32'h5C, 32'h0);

    repeat (2) @(negedge wb_clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
